ser_frame_sched: RTL and testbench
==================================

SER_FRAME_SCHED -- requirements
Module: ser_frame_sched

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of the payload-length field.
REQ-002 SHALL have parameter PREAMBLE, default 4'b0110, 4-bit frame start pattern.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req  input  4  per-requester frame request, level.
REQ-006 SHALL have port req_len  input  4*LEN_W  payload length in bits per requester, requester i at bits [i*LEN_W +: LEN_W].
REQ-007 SHALL have port data_in  input  4  payload bit per requester.
REQ-008 SHALL have port grant  output  4  one-hot owner of the current frame, zero when idle.
REQ-009 SHALL have port data_take  output  1  high when the granted requester's data_in bit is consumed this cycle.
REQ-010 SHALL have port ser_out  output  1  serial line bit.
REQ-011 SHALL have port ser_valid  output  1  ser_out carries a frame bit this cycle.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse in the last frame-bit cycle.

Function
REQ-014 SHALL implement states IDLE, PRE, PORT, LEN, DATA, GAP, plus PAR when enabled (REQ-029).
REQ-015 IDLE with any req bit high SHALL latch grant, port index, and the winner's req_len at that edge, then go to PRE; first preamble bit appears the cycle after req is sampled.
REQ-016 Arbitration SHALL be round-robin: search starts at (last granted index + 1) mod 4; after reset, the search starts at 0.
REQ-017 PRE SHALL send PREAMBLE MSB first over 4 cycles; PORT SHALL send the 2-bit index MSB first; LEN SHALL send the latched length MSB first over LEN_W cycles.
REQ-018 DATA SHALL last exactly length cycles, with ser_out = data_in[granted] and data_take = 1 each cycle; length SHALL be tracked by a down-counter loaded in LEN.
REQ-019 Latched length 0 SHALL skip DATA; LEN goes directly to GAP (or PAR).
REQ-020 GAP SHALL last one cycle with ser_valid = 0; it then returns to IDLE and clears grant.
REQ-021 ser_out SHALL be 0 whenever ser_valid = 0; ser_valid SHALL be 1 in PRE, PORT, LEN, DATA, and PAR.
REQ-022 Deasserting req mid-frame SHALL NOT abort the frame; req_len changes after the grant SHALL be ignored.
REQ-023 Requests arriving during a frame SHALL be served only from IDLE; no request is lost while held high.
REQ-024 done SHALL pulse in the final bit cycle (last LEN, DATA, or PAR bit).
REQ-025 Frame length SHALL be 4 + 2 + LEN_W + length (+1 with parity) cycles of ser_valid, plus 1 GAP cycle.

Reset
REQ-026 rst low SHALL immediately force IDLE, clear grant, data_take, ser_out, ser_valid, busy, done, and the counters, and reset the round-robin pointer to 0.
REQ-027 Reset asserted mid-frame SHALL truncate the frame with no further ser_valid; the first frame after release starts with PREAMBLE.

Configuration
REQ-028 Macro SER_FRAME_PARITY_EN SHALL select parity generation.
REQ-029 With SER_FRAME_PARITY_EN defined, a PAR state SHALL follow DATA (or LEN when length is 0) and send the even parity bit over port, length, and payload bits. Without it, no PAR state exists and the frame ends after DATA.

Structure
REQ-030 A shared package ser_frame_pkg SHALL hold the state encoding, the PREAMBLE default, the port width (2), and the LEN_W default.
REQ-031 Round-robin selection SHALL be a sub-module rr_arb4 (inputs req and last index; outputs one-hot grant and index).
REQ-032 The counters and the shift of the header fields SHALL live in ser_frame_sched alongside the state machine.

Verification
REQ-033 req=4'b0010, len1=3, data_in[1]=1,0,1 -> ser_out 0110,01,00000011,101; GAP; done in the cycle of the last payload bit.
REQ-034 req=4'b1111 held -> grants in order 0,1,2,3,0, each separated by one GAP cycle.
REQ-035 req=4'b0100, len2=0 -> 14 valid bits (15 with parity), data_take never high.
REQ-036 rst low during DATA -> same-cycle outputs zero; after release with req=4'b0001, a full frame with PREAMBLE first.
REQ-037 SER_FRAME_PARITY_EN, port 1, len 3, payload 101 -> parity bit 1 after payload.
REQ-038 req dropped and req_len changed mid-frame -> frame completes with original length and port.

Source files
------------

// File: rtl/ser_frame_pkg.sv
// Shared definitions for the serial frame scheduler.
// SER_FRAME_PARITY_EN adds the PAR state to the state encoding.
package ser_frame_pkg;

  localparam int         PORT_W           = 2;
  localparam int         LEN_W_DEFAULT    = 8;
  localparam logic [3:0] PREAMBLE_DEFAULT = 4'b0110;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_PORT = 3'd2,
    S_LEN  = 3'd3,
    S_DATA = 3'd4,
`ifdef SER_FRAME_PARITY_EN
    S_PAR  = 3'd5,
`endif
    S_GAP  = 3'd6
  } state_t;

endpackage

// File: rtl/rr_arb4.sv
// Four-way round-robin selector: the search begins one past the last owner.
module rr_arb4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_lastIdx,
  output logic [3:0] o_grant,
  output logic [1:0] o_idx,
  output logic       o_valid
);

  logic [1:0] w_cand;

  // Walk candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = 4; k >= 1; k--) begin
      w_cand = i_lastIdx + 2'(k);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
        o_grant = 4'b0001 << w_cand;
      end
    end
  end

endmodule

// File: rtl/ser_frame_sched.sv
// Serial frame scheduler: arbitrates four requesters and sends
// preamble, port index, length and payload on a single serial line.
// Define SER_FRAME_PARITY_EN to append an even parity bit to each frame.
import ser_frame_pkg::*;

module ser_frame_sched #(
  parameter int         LEN_W    = LEN_W_DEFAULT,
  parameter logic [3:0] PREAMBLE = PREAMBLE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*LEN_W-1:0] req_len,
  input  logic [3:0]         data_in,
  output logic [3:0]         grant,
  output logic               data_take,
  output logic               ser_out,
  output logic               ser_valid,
  output logic               busy,
  output logic               done
);

  localparam int HDR_W = 4 + PORT_W + LEN_W;
  localparam int CNT_W = $clog2(LEN_W + 4) + 1;

  state_t             r_state;
  state_t             w_nextState;
  logic [3:0]         r_grant;
  logic [1:0]         r_idx;
  logic [1:0]         r_lastIdx;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_dataCnt;
  logic [HDR_W-1:0]   r_shift;
  logic [CNT_W-1:0]   r_fieldCnt;
  logic               w_fieldLast;
  logic [3:0]         w_arbGrant;
  logic [1:0]         w_arbIdx;
  logic               w_arbValid;
  logic [LEN_W-1:0]   w_winLen;
`ifdef SER_FRAME_PARITY_EN
  logic               r_parity;
`endif

  // r_lastIdx resets to 3 so the first search after reset begins at requester 0.
  rr_arb4 u_arb (
    .i_req     (req),
    .i_lastIdx (r_lastIdx),
    .o_grant   (w_arbGrant),
    .o_idx     (w_arbIdx),
    .o_valid   (w_arbValid)
  );

  assign w_winLen    = req_len[w_arbIdx*LEN_W +: LEN_W];
  assign w_fieldLast = (r_fieldCnt == '0);
  assign grant       = r_grant;

  // State register; reset drops straight to IDLE, truncating any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nextState;
  end

  // Next state and serial outputs, decoded from the current state.
  always_comb begin
    w_nextState = r_state;
    ser_valid   = 1'b0;
    ser_out     = 1'b0;
    data_take   = 1'b0;
    done        = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_arbValid) w_nextState = S_PRE;
      end
      S_PRE: begin
        ser_valid = 1'b1;
        ser_out   = r_shift[HDR_W-1];
        if (w_fieldLast) w_nextState = S_PORT;
      end
      S_PORT: begin
        ser_valid = 1'b1;
        ser_out   = r_shift[HDR_W-1];
        if (w_fieldLast) w_nextState = S_LEN;
      end
      S_LEN: begin
        ser_valid = 1'b1;
        ser_out   = r_shift[HDR_W-1];
        if (w_fieldLast) begin
          if (r_len != '0) begin
            w_nextState = S_DATA;
          end else begin
`ifdef SER_FRAME_PARITY_EN
            w_nextState = S_PAR;
`else
            w_nextState = S_GAP;
            done        = 1'b1;
`endif
          end
        end
      end
      S_DATA: begin
        ser_valid = 1'b1;
        ser_out   = data_in[r_idx];
        data_take = 1'b1;
        if (r_dataCnt == LEN_W'(1)) begin
`ifdef SER_FRAME_PARITY_EN
          w_nextState = S_PAR;
`else
          w_nextState = S_GAP;
          done        = 1'b1;
`endif
        end
      end
`ifdef SER_FRAME_PARITY_EN
      S_PAR: begin
        ser_valid   = 1'b1;
        ser_out     = r_parity;
        done        = 1'b1;
        w_nextState = S_GAP;
      end
`endif
      S_GAP: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Grant latch, header shifter, field counter and payload down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant    <= '0;
      r_idx      <= '0;
      r_lastIdx  <= 2'd3;
      r_len      <= '0;
      r_dataCnt  <= '0;
      r_shift    <= '0;
      r_fieldCnt <= '0;
`ifdef SER_FRAME_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_arbValid) begin
            r_grant    <= w_arbGrant;
            r_idx      <= w_arbIdx;
            r_lastIdx  <= w_arbIdx;
            r_len      <= w_winLen;
            r_shift    <= {PREAMBLE, w_arbIdx, w_winLen};
            r_fieldCnt <= CNT_W'(3);
`ifdef SER_FRAME_PARITY_EN
            r_parity   <= 1'b0;
`endif
          end
        end
        S_PRE: begin
          r_shift    <= r_shift << 1;
          r_fieldCnt <= w_fieldLast ? CNT_W'(PORT_W - 1) : r_fieldCnt - CNT_W'(1);
        end
        S_PORT: begin
          r_shift    <= r_shift << 1;
          r_fieldCnt <= w_fieldLast ? CNT_W'(LEN_W - 1) : r_fieldCnt - CNT_W'(1);
`ifdef SER_FRAME_PARITY_EN
          r_parity   <= r_parity ^ r_shift[HDR_W-1];
`endif
        end
        S_LEN: begin
          r_shift    <= r_shift << 1;
          r_fieldCnt <= r_fieldCnt - CNT_W'(1);
          r_dataCnt  <= r_len;
`ifdef SER_FRAME_PARITY_EN
          r_parity   <= r_parity ^ r_shift[HDR_W-1];
`endif
        end
        S_DATA: begin
          r_dataCnt <= r_dataCnt - LEN_W'(1);
`ifdef SER_FRAME_PARITY_EN
          r_parity  <= r_parity ^ data_in[r_idx];
`endif
        end
        S_GAP: begin
          r_grant <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_frame_sched.sv
// Scoreboard bench for ser_frame_sched: every expected frame bit is
// queued when a request is set up and popped as the serial line emits it.
module tb_ser_frame_sched;

  localparam int         LEN_W = 8;
  localparam logic [3:0] PRE   = 4'b0110;

  typedef struct {
    logic       b;
    logic       dn;
    logic       tk;
    logic [3:0] g;
    int         frameLen;
  } exp_t;

  logic               clk;
  logic               rst;
  logic [3:0]         req;
  logic [4*LEN_W-1:0] reqLen;
  logic [3:0]         dataIn;
  logic [3:0]         grant;
  logic               dataTake;
  logic               serOut;
  logic               serValid;
  logic               busy;
  logic               done;

  exp_t        expQ[$];
  int          checkCount = 0;
  int          passCount  = 0;
  logic [63:0] payWord [4] = '{64'hA5C3_0F96_3C5A_E1B7, 64'h5A3C_96F0_C3A5_7E15,
                               64'h0FF0_1234_ABCD_8765, 64'hDEAD_BEEF_0BAD_F00D};
  int          ptr [4];
  int          expOff [4] = '{0, 0, 0, 0};
  logic        sampledTake = 1'b0;
  logic [3:0]  sampledGrant = 4'b0;
  int          frameBits = 0;

  ser_frame_sched #(.LEN_W(LEN_W), .PREAMBLE(PRE)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_len   (reqLen),
    .data_in   (dataIn),
    .grant     (grant),
    .data_take (dataTake),
    .ser_out   (serOut),
    .ser_valid (serValid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
  endtask

  task automatic setLen(input int idx, input int len);
    reqLen[idx*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  // Build the full expected bit sequence of one frame and queue it.
  task automatic applyStimulus(input int idx, input int len);
    logic             bits[$];
    logic             tks[$];
    logic             par;
    logic [3:0]       pre;
    logic [1:0]       ib;
    logic [LEN_W-1:0] lb;
    logic [63:0]      pw;
    exp_t             e;
    par = 1'b0;
    pre = PRE;
    ib  = 2'(idx);
    lb  = LEN_W'(len);
    pw  = payWord[idx];
    for (int k = 3; k >= 0; k--) begin bits.push_back(pre[k]); tks.push_back(1'b0); end
    for (int k = 1; k >= 0; k--) begin bits.push_back(ib[k]); tks.push_back(1'b0); par ^= ib[k]; end
    for (int k = LEN_W-1; k >= 0; k--) begin bits.push_back(lb[k]); tks.push_back(1'b0); par ^= lb[k]; end
    for (int k = 0; k < len; k++) begin
      bits.push_back(pw[(expOff[idx] + k) % 64]);
      tks.push_back(1'b1);
      par ^= pw[(expOff[idx] + k) % 64];
    end
    expOff[idx] += len;
`ifdef SER_FRAME_PARITY_EN
    bits.push_back(par);
    tks.push_back(1'b0);
`endif
    for (int k = 0; k < bits.size(); k++) begin
      e.b        = bits[k];
      e.tk       = tks[k];
      e.dn       = (k == bits.size() - 1);
      e.g        = 4'b0001 << idx;
      e.frameLen = bits.size();
      expQ.push_back(e);
    end
  endtask

  task automatic waitGrant();
    int ok;
    ok = 0;
    for (int c = 0; c < 20 && ok == 0; c++) begin
      @(posedge clk); #1;
      if (grant != 4'b0) ok = 1;
    end
    checkOutput("grantSeen", 32'(ok), 32'd1);
  endtask

  task automatic waitIdle();
    int ok;
    ok = 0;
    for (int c = 0; c < 500 && ok == 0; c++) begin
      @(negedge clk); #1;
      if (!busy && expQ.size() == 0) ok = 1;
    end
    checkOutput("idleReached", 32'(ok), 32'd1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("resetBusy", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) expOff[i] = ptr[i];
  endtask

  // Per-requester payload streams; a bit advances once the DUT has consumed it.
  initial begin
    for (int i = 0; i < 4; i++) ptr[i] = 0;
    forever begin
      for (int i = 0; i < 4; i++) dataIn[i] = payWord[i][ptr[i] % 64];
      @(posedge clk); #1;
      if (sampledTake) for (int i = 0; i < 4; i++) if (sampledGrant[i]) ptr[i]++;
    end
  end

  // Serial line monitor: pops the scoreboard on every valid bit.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      sampledTake  = dataTake;
      sampledGrant = grant;
      if (!rst) begin
        frameBits = 0;
      end else if (serValid) begin
        frameBits++;
        if (expQ.size() == 0) begin
          checkOutput("extraBit", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("serOut", {31'b0, serOut}, {31'b0, e.b});
          checkOutput("done", {31'b0, done}, {31'b0, e.dn});
          checkOutput("dataTake", {31'b0, dataTake}, {31'b0, e.tk});
          checkOutput("grant", {28'b0, grant}, {28'b0, e.g});
          if (e.dn) begin
            checkOutput("frameLen", 32'(frameBits), 32'(e.frameLen));
            frameBits = 0;
          end
        end
      end else begin
        checkOutput("idleLine", {29'b0, serOut, done, dataTake}, 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ok;
    int n;
    logic [3:0] prevG;
    rst    = 1'b0;
    req    = 4'b0;
    reqLen = '0;
    #1;
    checkOutput("rstGrant", {28'b0, grant}, 32'd0);
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    checkOutput("rstValid", {31'b0, serValid}, 32'd0);
    checkOutput("rstOut", {29'b0, serOut, done, dataTake}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Port 1, length 3, payload 1,0,1; check start latency and GAP.
    setLen(1, 3);
    applyStimulus(1, 3);
    @(posedge clk); #1 req = 4'b0010;
    @(posedge clk); #1;
    checkOutput("preFirst", {26'b0, serValid, serOut, grant}, {26'b0, 1'b1, 1'b0, 4'b0010});
    req = 4'b0;
    ok = 0;
    for (int c = 0; c < 100 && ok == 0; c++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    checkOutput("doneSeen", 32'(ok), 32'd1);
    @(negedge clk);
    checkOutput("gapCycle", {26'b0, busy, serValid, grant}, {26'b0, 1'b1, 1'b0, 4'b0010});
    @(negedge clk);
    checkOutput("afterGap", {27'b0, busy, grant}, 32'd0);
    waitIdle();

    // Request dropped and length changed after the grant.
    setLen(0, 2);
    applyStimulus(0, 2);
    @(posedge clk); #1 req = 4'b0001;
    waitGrant();
    req = 4'b0;
    setLen(0, 5);
    waitIdle();

    // Zero-length payload on port 2.
    setLen(2, 0);
    applyStimulus(2, 0);
    @(posedge clk); #1 req = 4'b0100;
    waitGrant();
    req = 4'b0;
    waitIdle();

    // All four requesting from reset: rotation 0,1,2,3,0.
    doReset();
    setLen(0, 1);
    setLen(1, 2);
    setLen(2, 3);
    setLen(3, 0);
    applyStimulus(0, 1);
    applyStimulus(1, 2);
    applyStimulus(2, 3);
    applyStimulus(3, 0);
    applyStimulus(0, 1);
    @(posedge clk); #1 req = 4'b1111;
    n = 0;
    prevG = grant;
    for (int c = 0; c < 3000 && n < 5; c++) begin
      @(posedge clk); #1;
      if (grant != 4'b0 && prevG == 4'b0) n++;
      prevG = grant;
    end
    checkOutput("rrGrants", 32'(n), 32'd5);
    req = 4'b0;
    waitIdle();

    // Reset in the middle of DATA, then a fresh frame.
    setLen(0, 4);
    applyStimulus(0, 4);
    @(posedge clk); #1 req = 4'b0001;
    waitGrant();
    req = 4'b0;
    ok = 0;
    for (int c = 0; c < 100 && ok == 0; c++) begin
      @(negedge clk);
      if (dataTake) ok = 1;
    end
    checkOutput("dataReached", 32'(ok), 32'd1);
    #2 rst = 1'b0;
    #1 checkOutput("midReset", {23'b0, grant, busy, serValid, serOut, done, dataTake}, 32'd0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) expOff[i] = ptr[i];
    applyStimulus(0, 4);
    @(posedge clk); #1 req = 4'b0001;
    waitGrant();
    req = 4'b0;
    waitIdle();

    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
